// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - write/read/clear bus of the multi-port register file
interface reg_file_mp_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] dat_in;
  logic [AW-1:0] rd_addrA;
  logic [AW-1:0] rd_addrB;
  logic [DW-1:0] datA_out;
  logic [DW-1:0] datB_out;
  logic          validA;
  logic          validB;
  logic          clr_req;
  logic          busy;
  logic          clr_done;

  modport master (
    output wr_en, wr_addr, dat_in, rd_addrA, rd_addrB, clr_req,
    input  datA_out, datB_out, validA, validB, busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, dat_in, rd_addrA, rd_addrB, clr_req,
    output datA_out, datB_out, validA, validB, busy, clr_done
  );
endinterface

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - 1W2R register file with valid bits, optional bypass and bulk clear
module reg_file_mp #(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  reg_file_mp_if.slave bus
);
  localparam int            DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    ptr;
  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             clr_done_q;
  logic             sweep_end;
  logic             wr_fire;
  logic             byp_live;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sweep_end = 1'b0;
    case (state)
      IDLE:  if (bus.clr_req) state_nxt = CLEAR;
      CLEAR: if (ptr == LAST) begin
        sweep_end = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_fire  = (state == IDLE) && bus.wr_en &&
                    !((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign byp_live = (BYPASS != 0) && (state == IDLE) && bus.wr_en;

  // ptr sits at 0 throughout IDLE, so entering CLEAR always starts the sweep at entry 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid      <= '0;
      ptr        <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= sweep_end;
      if (state == IDLE) begin
        if (wr_fire) begin
          mem[bus.wr_addr]   <= bus.dat_in;
          valid[bus.wr_addr] <= 1'b1;
        end
        ptr <= '0;
      end else begin
        mem[ptr]   <= '0;
        valid[ptr] <= 1'b0;
        ptr        <= ptr + 1'b1;
      end
    end
  end

  // Hardwired-zero entry takes priority over forwarding
  always_comb begin
    bus.datA_out = mem[bus.rd_addrA];
    bus.validA   = valid[bus.rd_addrA];
    if (byp_live && (bus.rd_addrA == bus.wr_addr)) begin
      bus.datA_out = bus.dat_in;
      bus.validA   = 1'b1;
    end
    if ((ZERO_REG != 0) && (bus.rd_addrA == '0)) begin
      bus.datA_out = '0;
      bus.validA   = 1'b1;
    end
  end

  always_comb begin
    bus.datB_out = mem[bus.rd_addrB];
    bus.validB   = valid[bus.rd_addrB];
    if (byp_live && (bus.rd_addrB == bus.wr_addr)) begin
      bus.datB_out = bus.dat_in;
      bus.validB   = 1'b1;
    end
    if ((ZERO_REG != 0) && (bus.rd_addrB == '0)) begin
      bus.datB_out = '0;
      bus.validB   = 1'b1;
    end
  end

  assign bus.busy     = (state == CLEAR);
  assign bus.clr_done = clr_done_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - random and directed checks of three reg_file_mp configurations
module tb_reg_file_mp;
  localparam int N = 3;  // 0: defaults, 1: BYPASS=0, 2: ZERO_REG=1

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       wr_en, clr_req;
  logic [3:0] wr_addr, ra, rb;
  logic [7:0] dat_in;

  logic [7:0] obs_da [N];
  logic [7:0] obs_db [N];
  logic       obs_va [N];
  logic       obs_vb [N];
  logic       obs_busy [N];
  logic       obs_done [N];

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;

  logic [7:0] m_mem [N][16];
  logic       m_val [N][16];
  logic       m_busy, m_done;
  int         m_idx;

  for (genvar k = 0; k < N; k++) begin : g_dut
    reg_file_mp_if #(.DW(8), .AW(4)) bus ();
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr;
    assign bus.dat_in   = dat_in;
    assign bus.rd_addrA = ra;
    assign bus.rd_addrB = rb;
    assign bus.clr_req  = clr_req;
    assign obs_da[k]    = bus.datA_out;
    assign obs_db[k]    = bus.datB_out;
    assign obs_va[k]    = bus.validA;
    assign obs_vb[k]    = bus.validB;
    assign obs_busy[k]  = bus.busy;
    assign obs_done[k]  = bus.clr_done;
    reg_file_mp #(.DW(8), .AW(4), .BYPASS(k == 1 ? 0 : 1), .ZERO_REG(k == 2 ? 1 : 0)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit byp(input int k); return k != 1; endfunction
  function automatic bit zr(input int k);  return k == 2; endfunction

  task automatic exp_read(input int k, input logic [3:0] a, output logic [7:0] d, output logic v);
    if (zr(k) && a == 4'd0) begin
      d = 8'h00; v = 1'b1;
    end else if (byp(k) && !m_busy && wr_en && a == wr_addr) begin
      d = dat_in; v = 1'b1;
    end else begin
      d = m_mem[k][a]; v = m_val[k][a];
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++)
      for (int a = 0; a < 16; a++) begin
        m_mem[k][a] = 8'h00;
        m_val[k][a] = 1'b0;
      end
    m_busy = 1'b0; m_done = 1'b0; m_idx = 0;
  endtask

  task automatic model_edge();
    if (!m_busy) begin
      if (wr_en)
        for (int k = 0; k < N; k++)
          if (!(zr(k) && wr_addr == 4'd0)) begin
            m_mem[k][wr_addr] = dat_in;
            m_val[k][wr_addr] = 1'b1;
          end
      m_done = 1'b0;
      if (clr_req) begin m_busy = 1'b1; m_idx = 0; end
    end else begin
      for (int k = 0; k < N; k++) begin
        m_mem[k][m_idx] = 8'h00;
        m_val[k][m_idx] = 1'b0;
      end
      m_idx++;
      m_done = (m_idx == 16);
      if (m_done) m_busy = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic [7:0] d;
    logic       v;
    if (obs_busy[0] === 1'b1) busy_cnt++;
    for (int k = 0; k < N; k++) begin
      exp_read(k, ra, d, v);
      check($sformatf("d%0d_datA@%0d", k, ra), obs_da[k], d);
      check($sformatf("d%0d_validA@%0d", k, ra), obs_va[k], v);
      exp_read(k, rb, d, v);
      check($sformatf("d%0d_datB@%0d", k, rb), obs_db[k], d);
      check($sformatf("d%0d_validB@%0d", k, rb), obs_vb[k], v);
      check($sformatf("d%0d_busy", k), obs_busy[k], m_busy);
      check($sformatf("d%0d_clr_done", k), obs_done[k], m_done);
    end
  endtask

  task automatic set_in(input logic we, input logic [3:0] wa, input logic [7:0] di,
                        input logic [3:0] a, input logic [3:0] b, input logic cr);
    wr_en = we; wr_addr = wa; dat_in = di; ra = a; rb = b; clr_req = cr;
  endtask

  task automatic half();   @(negedge clk); compare_all(); endtask
  task automatic finish_cycle(); @(posedge clk); model_edge(); #1; endtask
  task automatic run_cycle(); half(); finish_cycle(); endtask

  task automatic fill_all();
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 4'(i), 8'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      run_cycle();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(1'b0, 4'd0, 8'h00, 4'd0, 4'd5, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    run_cycle();
    check("rst_busy", obs_busy[0], 1'b0);

    // Same-cycle forwarding and hold on the default configuration
    set_in(1'b1, 4'd3, 8'hA5, 4'd3, 4'd0, 1'b0);
    half();
    check("byp_dat", obs_da[0], 8'hA5);
    check("byp_valid", obs_va[0], 1'b1);
    finish_cycle();
    set_in(1'b0, 4'd0, 8'h00, 4'd3, 4'd0, 1'b0);
    half();
    check("hold_dat", obs_da[0], 8'hA5);
    finish_cycle();

    // No forwarding on the BYPASS=0 instance
    set_in(1'b1, 4'd7, 8'h3C, 4'd1, 4'd7, 1'b0);
    half();
    check("nobyp_dat_wr", obs_db[1], 8'h00);
    check("nobyp_valid_wr", obs_vb[1], 1'b0);
    finish_cycle();
    set_in(1'b0, 4'd0, 8'h00, 4'd1, 4'd7, 1'b0);
    half();
    check("nobyp_dat_next", obs_db[1], 8'h3C);
    check("nobyp_valid_next", obs_vb[1], 1'b1);
    finish_cycle();

    // Hardwired zero entry on the ZERO_REG=1 instance
    set_in(1'b1, 4'd0, 8'hFF, 4'd0, 4'd0, 1'b0);
    half();
    check("zr_dat_wr", obs_da[2], 8'h00);
    check("zr_valid_wr", obs_va[2], 1'b1);
    finish_cycle();
    set_in(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
    half();
    check("zr_dat_next", obs_da[2], 8'h00);
    finish_cycle();

    // Full sweep with a write dropped in CLEAR cycle 2; A reads a cleared entry, B the next victim
    fill_all();
    set_in(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
    run_cycle();
    busy_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      set_in(c == 2, 4'd5, 8'h77, 4'((c + 14) % 16), 4'(c - 1), 1'b0);
      run_cycle();
    end
    set_in(1'b0, 4'd0, 8'h00, 4'd5, 4'd5, 1'b0);
    half();
    check("sweep_done", obs_done[0], 1'b1);
    check("drop_validB", obs_vb[0], 1'b0);
    finish_cycle();
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 4'd0, 8'h00, 4'(i), 4'(15 - i), 1'b0);
      run_cycle();
    end
    check("sweep_len", busy_cnt, 16);

    // Back-to-back sweeps with clr_req held high
    busy_cnt = 0;
    for (int c = 0; c < 34; c++) begin
      set_in(1'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), 4'($urandom), 1'b1);
      run_cycle();
    end
    set_in(1'b0, 4'd0, 8'h00, 4'd2, 4'd3, 1'b0);
    run_cycle();
    run_cycle();
    check("b2b_len", busy_cnt, 32);

    // Reset asserted in CLEAR cycle 6 aborts the sweep
    fill_all();
    set_in(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
    run_cycle();
    for (int c = 1; c <= 5; c++) begin
      set_in(1'b0, 4'd0, 8'h00, 4'(c), 4'(c + 8), 1'b0);
      run_cycle();
    end
    set_in(1'b0, 4'd0, 8'h00, 4'd9, 4'd12, 1'b0);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("abort_busy", obs_busy[0], 1'b0);
    compare_all();
    @(posedge clk);
    #1 reset_n = 1'b1;
    run_cycle();
    run_cycle();
    set_in(1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
    run_cycle();
    busy_cnt = 0;
    set_in(1'b0, 4'd0, 8'h00, 4'd4, 4'd15, 1'b0);
    repeat (20) run_cycle();
    check("post_abort_len", busy_cnt, 16);

    // Random traffic with occasional clears
    for (int n = 0; n < 1500; n++) begin
      set_in(1'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), 4'($urandom),
             $urandom_range(0, 39) == 0);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DW, default 8, data width in bits.
REQ-002 Parameter AW, default 4, address width; depth = 2**AW entries.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 Parameter ZERO_REG, default 0, 1 = entry 0 hardwired to zero.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 wr_en  input  1  write enable.
REQ-008 wr_addr  input  AW  write address.
REQ-009 dat_in  input  DW  write data.
REQ-010 rd_addrA  input  AW  read port A address.
REQ-011 rd_addrB  input  AW  read port B address.
REQ-012 datA_out  output  DW  port A read data, combinational.
REQ-013 datB_out  output  DW  port B read data, combinational.
REQ-014 validA  output  1  port A entry written since last reset/clear.
REQ-015 validB  output  1  port B entry written since last reset/clear.
REQ-016 clr_req  input  1  bulk-clear request, sampled when idle.
REQ-017 busy  output  1  bulk clear in progress.
REQ-018 clr_done  output  1  one-cycle pulse when bulk clear completes.

Function
REQ-019 Storage: 2**AW entries of DW bits plus one valid bit per entry.
REQ-020 Write: in IDLE with wr_en=1, entry[wr_addr] <= dat_in and valid[wr_addr] <= 1 at the clock edge.
REQ-021 Reads: datX_out = entry[rd_addrX], validX = valid[rd_addrX], zero-cycle latency, both ports independent; same address on both ports is legal.
REQ-022 BYPASS=1: in IDLE, if wr_en=1 and rd_addrX==wr_addr, datX_out = dat_in and validX = 1 in the same cycle.
REQ-023 BYPASS=0: written data visible on reads from the cycle after the write edge.
REQ-024 ZERO_REG=1: writes to address 0 discarded; reads of address 0 return 0 with valid=1, bypass not applied.
REQ-025 FSM states IDLE and CLEAR; reset state IDLE.
REQ-026 IDLE -> CLEAR when clr_req=1 at a clock edge; clear pointer loaded with 0; a write in that same cycle is performed.
REQ-027 CLEAR: each cycle entry[ptr] <= 0, valid[ptr] <= 0, ptr increments by 1; takes exactly 2**AW cycles.
REQ-028 CLEAR -> IDLE on the edge that clears entry 2**AW-1; clr_done = 1 for the following cycle only.
REQ-029 busy = 1 exactly while in CLEAR; clr_req ignored while busy.
REQ-030 Writes while busy are dropped, not queued; bypass disabled while busy.
REQ-031 Reads while busy return stored contents: already-cleared entries read 0/valid 0, others old values.
REQ-032 Pointer wrap: the pointer never exceeds 2**AW-1; no entry cleared twice per sweep.
REQ-033 Back-to-back clear: clr_req held high re-enters CLEAR on the edge after the first clr_done cycle.

Reset
REQ-034 reset_n=0 asynchronously: all entries 0, all valid 0, FSM IDLE, ptr 0, busy 0, clr_done 0.
REQ-035 reset_n=0 mid-CLEAR aborts the sweep; no clr_done pulse generated.
REQ-036 Outputs after reset: datA_out=datB_out=0, validA=validB=0 (validX=1 for address 0 when ZERO_REG=1).

Verification
REQ-037 Defaults; write 8'hA5 to addr 3, read A=3 same cycle -> datA_out=8'hA5, validA=1 (BYPASS=1); next cycle still 8'hA5.
REQ-038 BYPASS=0; write 8'h3C to addr 7 with rd_addrB=7 -> datB_out=0, validB=0 in write cycle, 8'h3C/1 next cycle.
REQ-039 Fill all 16 entries, pulse clr_req -> busy high 16 cycles, entries cleared in order 0..15, clr_done high for 1 cycle after, all reads 0/valid 0.
REQ-040 Write addr 5 during cycle 2 of CLEAR -> write dropped; after clr_done entry 5 reads 0, validB=0.
REQ-041 ZERO_REG=1; write 8'hFF to addr 0 -> datA_out=0, validA=1 both same and next cycle.
REQ-042 Assert reset_n=0 at CLEAR cycle 6 -> busy falls immediately, all entries 0, no clr_done; new clr_req after release starts a full 16-cycle sweep.
